uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have one clock, clk_in, and one asynchronous active-low reset, reset_n.
REQ-002 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range is 5..9.
REQ-003 Parameter OVERSAMPLE, default 16, SHALL set clk_in cycles per bit; it SHALL be even and at least 4.
REQ-004 Parameter PARITY_MODE, default 0, SHALL select parity: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values are 1 and 2.
REQ-006 Port clk_in SHALL be input, 1 bit: sampling clock at OVERSAMPLE x baud.
REQ-007 Port reset_n SHALL be input, 1 bit: asynchronous active-low reset.
REQ-008 Port rx_data SHALL be input, 1 bit: asynchronous serial line, idle high.
REQ-009 Port data SHALL be output, DATA_BITS wide: received word.
REQ-010 Port data_valid SHALL be output, 1 bit: data and status are valid.
REQ-011 Port data_ready SHALL be input, 1 bit: consumer accepts the word.
REQ-012 Port parity_err SHALL be output, 1 bit: parity mismatch for the held word.
REQ-013 Port frame_err SHALL be output, 1 bit: a stop bit was sampled low for the held word.
REQ-014 Port overrun_err SHALL be output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-015 Port busy SHALL be output, 1 bit: the state machine is not in IDLE.

Function
REQ-016 rx_data SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value.
REQ-017 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-018 IDLE SHALL go to START on the first cycle the synchronized line is 0, and SHALL clear the bit counter and the cycle counter.
REQ-019 START SHALL sample the line OVERSAMPLE/2 cycles after entry: a 1 (false start) SHALL return to IDLE with no output; a 0 SHALL go to DATA with the cycle counter cleared.
REQ-020 DATA SHALL sample every OVERSAMPLE cycles, so each sample falls at mid-bit, and SHALL shift the bits in LSB first.
REQ-021 After DATA_BITS samples, DATA SHALL go to PARITY if PARITY_MODE is nonzero, else to STOP.
REQ-022 PARITY SHALL sample one bit and SHALL flag a mismatch if the XOR of the data bits and the parity bit is 1 (even mode) or 0 (odd mode).
REQ-023 STOP SHALL sample STOP_BITS bits; any stop sample of 0 SHALL set the frame error.
REQ-024 STOP SHALL go to IDLE on the cycle after the final stop sample.
REQ-025 On the cycle after the final stop sample, data, parity_err and frame_err SHALL be loaded and data_valid SHALL be set, unless data_valid is already high (see REQ-028).
REQ-026 data_valid SHALL stay high, with data, parity_err and frame_err stable, until a cycle in which data_ready is 1.
REQ-027 data_valid SHALL clear on the cycle after the handshake.
REQ-028 If a frame completes while data_valid is high and data_ready is 0, the new frame SHALL be discarded, the held word SHALL be kept, and overrun_err SHALL pulse for one cycle.
REQ-029 If a frame completes in the same cycle as a handshake, the new word SHALL be loaded, data_valid SHALL stay high, and no overrun SHALL be flagged.
REQ-030 A frame with the line low throughout (break) SHALL deliver data of 0 with frame_err set.
REQ-031 Reception SHALL run independently of the handshake, so back-to-back frames need no idle gap.
REQ-032 Counters SHALL be sized with clog2 of OVERSAMPLE and of DATA_BITS+1, and SHALL never wrap inside a state.

Reset
REQ-033 While reset_n is 0, the state SHALL be IDLE, all counters 0, data 0, and data_valid, parity_err, frame_err, overrun_err and busy 0.
REQ-034 The synchronizer flops SHALL reset to 1.
REQ-035 A reset during a frame SHALL abandon the frame with no output.
REQ-036 After reset release, detection SHALL wait for a fresh falling edge.

Structure
REQ-037 Package uart_pkg SHALL hold the state encoding, the PARITY_NONE/EVEN/ODD constants and the stop-bit constants.
REQ-038 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer, with the same clock and reset ports.
REQ-039 All other logic SHALL be in uart_receiver.

Verification
REQ-040 8N1, OVERSAMPLE=16, frame 0x55, data_ready held 1 -> data=0x55, data_valid high for 1 cycle, both error flags 0.
REQ-041 8E1, frame 0xA3 sent with parity bit 1 -> data=0xA3, parity_err=1, frame_err=0.
REQ-042 8N1, frame 0x3C with the stop bit driven 0 -> data=0x3C, frame_err=1; then the line goes high and the next frame 0x01 is received correctly.
REQ-043 Low glitch of 5 clk_in cycles on an idle line -> returns to IDLE, data_valid stays 0.
REQ-044 Two frames 0x11 then 0x22 with data_ready=0 -> data stays 0x11, overrun_err pulses once; asserting data_ready then clears data_valid.
REQ-045 7O2 mode, reset_n pulsed low during the 4th data bit -> all outputs 0; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and parity/stop-bit constants for the UART receiver.
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  localparam int STOP_ONE    = 1;
  localparam int STOP_TWO    = 2;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resetting to the idle level.
module uart_rx_sync (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver with optional parity, 1/2 stop bits
// and a valid/ready output holding register with overrun detection.
module uart_receiver import uart_pkg::*; #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = STOP_ONE
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  rx_state_t state;
  logic [CW-1:0] cyc;
  logic [BW-1:0] bits;
  logic [DATA_BITS-1:0] shreg;
  logic rx_s, par_r, frm_r, done, tick, last_data, last_stop, hold;
  uart_rx_sync u_sync (.clk_in(clk_in), .reset_n(reset_n), .d(rx_data), .q(rx_s));
  // START samples half a bit in; every later state samples one full bit after the previous sample
  assign tick      = cyc == (state == S_START ? HALF : LAST);
  assign last_data = bits == BW'(DATA_BITS - 1);
  assign last_stop = bits == BW'(STOP_BITS - 1);
  assign busy      = state != S_IDLE;
  assign hold      = data_valid && !data_ready;
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cyc   <= '0;
      bits  <= '0;
      shreg <= '0;
      par_r <= 1'b0;
      frm_r <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      cyc  <= (state == S_IDLE || tick) ? '0 : cyc + CW'(1);
      case (state)
        S_IDLE: begin
          bits <= '0;
          if (!rx_s) begin
            state <= S_START;
            par_r <= 1'b0;
            frm_r <= 1'b0;
          end
        end
        S_START: if (tick) state <= rx_s ? S_IDLE : S_DATA;
        S_DATA: if (tick) begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          bits  <= last_data ? '0 : bits + BW'(1);
          if (last_data) state <= PARITY_MODE != PARITY_NONE ? S_PARITY : S_STOP;
        end
        S_PARITY: if (tick) begin
          par_r <= ^shreg ^ rx_s ^ (PARITY_MODE == PARITY_ODD);
          state <= S_STOP;
        end
        S_STOP: if (tick) begin
          frm_r <= frm_r | ~rx_s;
          bits  <= last_stop ? '0 : bits + BW'(1);
          if (last_stop) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // A completed frame is dropped only if the held word is not being consumed this cycle
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      data        <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= done && hold;
      if (done && !hold) begin
        data       <= shreg;
        parity_err <= par_r;
        frame_err  <= frm_r;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) data_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed checks of 8N1, 8E1 and 7O2 receivers driven from hand-built frames.
module tb_uart_receiver;
  logic clk_in = 1'b0, reset_n = 1'b0;
  logic rx_n = 1'b1, rx_e = 1'b1, rx_o = 1'b1;
  logic ready_n = 1'b0, ready_e = 1'b0, ready_o = 1'b0;
  logic [7:0] data_n, data_e;
  logic [6:0] data_o;
  logic valid_n, valid_e, valid_o, pe_n, pe_e, pe_o, fe_n, fe_e, fe_o;
  logic ovr_n, ovr_e, ovr_o, busy_n, busy_e, busy_o;
  int checks = 0, fails = 0;
  int vcnt_n = 0, ovcnt_n = 0, vcnt_o = 0;
  logic [7:0] cap_n = '0;
  logic [6:0] cap_o = '0;
  logic cap_pe_n = 1'b0, cap_fe_n = 1'b0, cap_pe_o = 1'b0, cap_fe_o = 1'b0;

  always #5 clk_in = ~clk_in;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) dut_n (
    .clk_in(clk_in), .reset_n(reset_n), .rx_data(rx_n), .data(data_n), .data_valid(valid_n),
    .data_ready(ready_n), .parity_err(pe_n), .frame_err(fe_n), .overrun_err(ovr_n), .busy(busy_n));
  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) dut_e (
    .clk_in(clk_in), .reset_n(reset_n), .rx_data(rx_e), .data(data_e), .data_valid(valid_e),
    .data_ready(ready_e), .parity_err(pe_e), .frame_err(fe_e), .overrun_err(ovr_e), .busy(busy_e));
  uart_receiver #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(2)) dut_o (
    .clk_in(clk_in), .reset_n(reset_n), .rx_data(rx_o), .data(data_o), .data_valid(valid_o),
    .data_ready(ready_o), .parity_err(pe_o), .frame_err(fe_o), .overrun_err(ovr_o), .busy(busy_o));

  always @(negedge clk_in) begin
    if (valid_n) begin vcnt_n++; cap_n = data_n; cap_pe_n = pe_n; cap_fe_n = fe_n; end
    if (ovr_n) ovcnt_n++;
    if (valid_o) begin vcnt_o++; cap_o = data_o; cap_pe_o = pe_o; cap_fe_o = fe_o; end
  end

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx_n = v;
      1: rx_e = v;
      default: rx_o = v;
    endcase
  endtask

  task automatic send_bit(input int which, input logic v);
    set_rx(which, v);
    repeat (16) @(negedge clk_in);
  endtask

  // pmode: 0 none, 1 even, 2 odd; pflip inverts the correct parity bit
  task automatic send(input int which, input logic [8:0] d, input int nb, input int pmode,
                      input logic pflip, input int ns, input logic stopv);
    logic p;
    p = (pmode == 2);
    send_bit(which, 1'b0);
    for (int i = 0; i < nb; i++) begin
      send_bit(which, d[i]);
      p = p ^ d[i];
    end
    if (pmode != 0) send_bit(which, p ^ pflip);
    for (int i = 0; i < ns; i++) send_bit(which, stopv);
    set_rx(which, 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_in);
    checks++; if (data_n !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data_n); end
    checks++; if (valid_n !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_n); end
    checks++; if ({pe_n, fe_n, ovr_n} !== 3'b000) begin fails++; $display("FAIL reset_errs: got %b want 000", {pe_n, fe_n, ovr_n}); end
    checks++; if ({busy_n, busy_e, busy_o} !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b want 000", {busy_n, busy_e, busy_o}); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk_in);
    checks++; if ({valid_n, valid_e, valid_o} !== 3'b000) begin fails++; $display("FAIL post_reset_valid: got %b want 000", {valid_n, valid_e, valid_o}); end
    checks++; if ({busy_n, busy_e, busy_o} !== 3'b000) begin fails++; $display("FAIL post_reset_busy: got %b want 000", {busy_n, busy_e, busy_o}); end
  endtask

  task automatic test_8n1;
    int v0;
    ready_n = 1'b1;
    v0 = vcnt_n;
    send(0, 9'h055, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk_in);
    checks++; if (vcnt_n - v0 !== 1) begin fails++; $display("FAIL 8n1_valid_cycles: got %0d want 1", vcnt_n - v0); end
    checks++; if (cap_n !== 8'h55) begin fails++; $display("FAIL 8n1_data: got %h want 55", cap_n); end
    checks++; if ({cap_pe_n, cap_fe_n} !== 2'b00) begin fails++; $display("FAIL 8n1_errs: got %b want 00", {cap_pe_n, cap_fe_n}); end
    checks++; if (busy_n !== 1'b0) begin fails++; $display("FAIL 8n1_busy: got %b want 0", busy_n); end
  endtask

  task automatic test_parity;
    send(1, 9'h0A3, 8, 1, 1'b1, 1, 1'b1);
    repeat (4) @(negedge clk_in);
    checks++; if (valid_e !== 1'b1) begin fails++; $display("FAIL par_valid: got %b want 1", valid_e); end
    checks++; if (data_e !== 8'hA3) begin fails++; $display("FAIL par_data: got %h want a3", data_e); end
    checks++; if ({pe_e, fe_e} !== 2'b10) begin fails++; $display("FAIL par_errs: got %b want 10", {pe_e, fe_e}); end
    ready_e = 1'b1;
    @(negedge clk_in);
    ready_e = 1'b0;
    checks++; if (valid_e !== 1'b0) begin fails++; $display("FAIL par_handshake: got %b want 0", valid_e); end
    send(1, 9'h007, 8, 1, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk_in);
    checks++; if ({valid_e, data_e} !== {1'b1, 8'h07}) begin fails++; $display("FAIL par_good_data: got %b/%h want 1/07", valid_e, data_e); end
    checks++; if ({pe_e, fe_e} !== 2'b00) begin fails++; $display("FAIL par_good_errs: got %b want 00", {pe_e, fe_e}); end
  endtask

  task automatic test_frame_err;
    send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0);
    repeat (4) @(negedge clk_in);
    checks++; if (cap_n !== 8'h3C) begin fails++; $display("FAIL ferr_data: got %h want 3c", cap_n); end
    checks++; if ({cap_pe_n, cap_fe_n} !== 2'b01) begin fails++; $display("FAIL ferr_flags: got %b want 01", {cap_pe_n, cap_fe_n}); end
    repeat (20) @(negedge clk_in);
    checks++; if (busy_n !== 1'b0) begin fails++; $display("FAIL ferr_idle: got %b want 0", busy_n); end
    send(0, 9'h001, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk_in);
    checks++; if ({cap_n, cap_fe_n} !== {8'h01, 1'b0}) begin fails++; $display("FAIL ferr_next: got %h/%b want 01/0", cap_n, cap_fe_n); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcnt_n;
    rx_n = 1'b0;
    repeat (4) @(negedge clk_in);
    checks++; if (busy_n !== 1'b1) begin fails++; $display("FAIL glitch_start: got %b want 1", busy_n); end
    @(negedge clk_in);
    rx_n = 1'b1;
    repeat (20) @(negedge clk_in);
    checks++; if (busy_n !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", busy_n); end
    checks++; if (vcnt_n !== v0) begin fails++; $display("FAIL glitch_valid: got %0d valid cycles want 0", vcnt_n - v0); end
  endtask

  task automatic test_back_to_back_overrun;
    int o0;
    ready_n = 1'b0;
    o0 = ovcnt_n;
    send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk_in);
    checks++; if ({valid_n, data_n} !== {1'b1, 8'h11}) begin fails++; $display("FAIL ovr_held: got %b/%h want 1/11", valid_n, data_n); end
    checks++; if (ovcnt_n - o0 !== 1) begin fails++; $display("FAIL ovr_pulses: got %0d want 1", ovcnt_n - o0); end
    ready_n = 1'b1;
    @(negedge clk_in);
    checks++; if (valid_n !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", valid_n); end
  endtask

  task automatic test_reset_midframe;
    ready_o = 1'b1;
    send_bit(2, 1'b0);
    send_bit(2, 1'b0);
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    rx_o = 1'b1;
    repeat (8) @(negedge clk_in);
    checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy_o); end
    reset_n = 1'b0;
    @(negedge clk_in);
    checks++; if ({busy_o, valid_o, data_o, pe_o, fe_o, ovr_o} !== 12'h000) begin fails++; $display("FAIL mid_reset_o: got %h want 000", {busy_o, valid_o, data_o, pe_o, fe_o, ovr_o}); end
    checks++; if ({valid_e, data_e} !== 9'h000) begin fails++; $display("FAIL mid_reset_e: got %h want 000", {valid_e, data_e}); end
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_in);
    checks++; if ({busy_o, vcnt_o} !== {1'b0, 32'd0}) begin fails++; $display("FAIL mid_abandon: busy %b valid cycles %0d want 0/0", busy_o, vcnt_o); end
    send(2, 9'h05A, 7, 2, 1'b0, 2, 1'b1);
    repeat (4) @(negedge clk_in);
    checks++; if (cap_o !== 7'h5A) begin fails++; $display("FAIL 7o2_data: got %h want 5a", cap_o); end
    checks++; if ({cap_pe_o, cap_fe_o} !== 2'b00) begin fails++; $display("FAIL 7o2_errs: got %b want 00", {cap_pe_o, cap_fe_o}); end
    checks++; if (vcnt_o !== 1) begin fails++; $display("FAIL 7o2_valid_cycles: got %0d want 1", vcnt_o); end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_frame_err;
    test_glitch;
    test_back_to_back_overrun;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
